// File: rtl/int_mac_seq_if.sv
// int_mac_seq_if: bundles the job, operand, MAC and result signals of the
// integer MAC operand sequencer.
//   master : the surrounding environment (operand fetch, MAC stage, write-back)
//   slave  : the sequencer itself (int_mac_seq)
// Ports carried:
//   start_* : job descriptor handshake (mode, step count, packed bias)
//   op_*    : operand beat handshake, 32 b packed A/B words
//   mac_*   : MAC adder stage IN1/IN2/IN3/mode and its combinational OUT
//   res_*   : final 128 b packed partial sums with valid/ready
interface int_mac_seq_if #(
  parameter int K_W = 8
);
  logic           start_valid;
  logic           start_ready;
  logic           start_mode;
  logic [K_W-1:0] start_klen;
  logic [127:0]   start_bias;

  logic           op_valid;
  logic           op_ready;
  logic [31:0]    op_a;
  logic [31:0]    op_b;

  logic [31:0]    mac_in1;
  logic [31:0]    mac_in2;
  logic [127:0]   mac_in3;
  logic           mac_mode;
  logic [127:0]   mac_out;

  logic           res_valid;
  logic           res_ready;
  logic [127:0]   res_data;

  modport master (
    output start_valid, start_mode, start_klen, start_bias,
    output op_valid, op_a, op_b, res_ready, mac_out,
    input  start_ready, op_ready, mac_in1, mac_in2, mac_in3, mac_mode,
    input  res_valid, res_data
  );

  modport slave (
    input  start_valid, start_mode, start_klen, start_bias,
    input  op_valid, op_a, op_b, res_ready, mac_out,
    output start_ready, op_ready, mac_in1, mac_in2, mac_in3, mac_mode,
    output res_valid, res_data
  );
endinterface

// File: rtl/int_mac_seq.sv
// int_mac_seq: operand sequencer and accumulator owner for the 4xINT8 /
// 8xINT4 MAC adder stage. Accepts a job (mode, k_len, bias), streams k_len
// operand beats through the MAC feeding each MAC result back as the next
// addend, then presents the 128 b accumulator downstream.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : int_mac_seq_if.slave (job, operand, MAC and result signals)
// Lane arithmetic lives entirely in the MAC; this block only moves words.
module int_mac_seq #(
  parameter int K_W = 8   // must match the K_W of the connected interface
) (
  input  logic          clk,
  input  logic          rst,
  int_mac_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [127:0]   acc_q,   acc_d;
  logic [K_W-1:0] cnt_q,   cnt_d;
  logic [K_W-1:0] klen_q,  klen_d;
  logic           mode_q,  mode_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      klen_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_valid) begin
          acc_d  = bus.start_bias;
          mode_d = bus.start_mode;
          klen_d = bus.start_klen;
          cnt_d  = '0;
          // an empty job goes straight to the result with the bias as-is
          state_d = (bus.start_klen != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (bus.op_valid) begin
          acc_d = bus.mac_out;
          cnt_d = cnt_q + K_W'(1);
          if (cnt_q == klen_q - K_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // handshakes are pure state decodes: no input-to-ready/valid paths
  assign bus.start_ready = (state_q == S_IDLE);
  assign bus.op_ready    = (state_q == S_RUN);
  assign bus.res_valid   = (state_q == S_DONE);
  assign bus.res_data    = acc_q;

  assign bus.mac_in1  = bus.op_a;
  assign bus.mac_in2  = bus.op_b;
  assign bus.mac_in3  = acc_q;
  assign bus.mac_mode = mode_q;

endmodule

// File: tb/tb_int_mac_seq.sv
module tb_int_mac_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_mac_seq_if #(.K_W(8)) bus();
  int_mac_seq #(.K_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int total = 0;
  int bad   = 0;

  // ---------------- MAC stage stand-in (signed lanes, wrap per lane) -------
  function automatic logic [127:0] mac_stub(input logic [31:0] a, input logic [31:0] b,
                                            input logic [127:0] c, input logic m);
    logic [127:0] o;
    logic signed [15:0] p8;
    logic signed [7:0]  p4;
    o = c;
    if (m) begin
      for (int i = 0; i < 4; i++) begin
        p8 = 16'($signed(a[8*i +: 8])) * 16'($signed(b[8*i +: 8]));
        o[32*i +: 32] = c[32*i +: 32] + {{16{p8[15]}}, p8};
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        p4 = 8'($signed(a[4*i +: 4])) * 8'($signed(b[4*i +: 4]));
        o[16*i +: 16] = c[16*i +: 16] + {{8{p4[7]}}, p4};
      end
    end
    return o;
  endfunction

  assign bus.mac_out = mac_stub(bus.mac_in1, bus.mac_in2, bus.mac_in3, bus.mac_mode);

  // ---------------- reference model: bias plus plain sum of products -------
  longint       m_sum [8];
  logic [127:0] m_bias;
  bit           m_mode, m_run, m_done, m_live;
  int           m_left;

  function automatic longint lane_prod(input logic [31:0] a, input logic [31:0] b,
                                       input bit md, input int i);
    byte sa, sb;
    logic signed [3:0] xa, xb;
    if (md) begin
      sa = a[8*i +: 8]; sb = b[8*i +: 8];
      return longint'(sa) * longint'(sb);
    end
    xa = a[4*i +: 4]; xb = b[4*i +: 4];
    return longint'(xa) * longint'(xb);
  endfunction

  function automatic logic [127:0] m_acc();
    logic [127:0] r;
    r = '0;
    if (m_mode) for (int i = 0; i < 4; i++) r[32*i +: 32] = m_bias[32*i +: 32] + 32'(m_sum[i]);
    else        for (int i = 0; i < 8; i++) r[16*i +: 16] = m_bias[16*i +: 16] + 16'(m_sum[i]);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_done = 0; m_bias = '0; m_mode = 0; m_left = 0; m_live = 1;
      for (int i = 0; i < 8; i++) m_sum[i] = 0;
    end else if (m_done) begin
      if (bus.res_ready) m_done = 0;
    end else if (m_run) begin
      if (bus.op_valid) begin
        for (int i = 0; i < (m_mode ? 4 : 8); i++) m_sum[i] += lane_prod(bus.op_a, bus.op_b, m_mode, i);
        m_left--;
        if (m_left == 0) begin m_run = 0; m_done = 1; end
      end
    end else if (bus.start_valid) begin
      m_bias = bus.start_bias; m_mode = bus.start_mode; m_left = int'(bus.start_klen);
      for (int i = 0; i < 8; i++) m_sum[i] = 0;
      if (m_left == 0) m_done = 1; else m_run = 1;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      chk("start_ready", 128'(bus.start_ready), 128'(!(m_run || m_done)));
      chk("op_ready",    128'(bus.op_ready),    128'(m_run));
      chk("res_valid",   128'(bus.res_valid),   128'(m_done));
      chk("mac_in3",     bus.mac_in3,           m_acc());
      chk("mac_mode",    128'(bus.mac_mode),    128'(m_mode));
      chk("mac_in12",    {bus.mac_in1, bus.mac_in2}, {bus.op_a, bus.op_b});
      if (m_done) chk("res_data", bus.res_data, m_acc());
    end
  end

  // ---------------- stimulus -----------------------------------------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_job(input bit md, input int kl, input logic [127:0] bias,
                         input bit fixed, input logic [31:0] fa, input logic [31:0] fb,
                         input int gap_max, input int hold, output logic [127:0] res);
    int g;
    bus.start_valid = 1'b1; bus.start_mode = md; bus.start_klen = 8'(kl); bus.start_bias = bias;
    g = 0;
    while (!bus.start_ready && g < 50) begin tick(); g++; end
    chk("start_wait", 128'(g < 50), 128'(1));
    tick();
    bus.start_valid = 1'b0;
    bus.start_bias  = {$urandom, $urandom, $urandom, $urandom};
    for (int b = 0; b < kl; b++) begin
      repeat ($urandom_range(0, gap_max)) begin
        bus.op_valid = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom;
        tick();
      end
      bus.op_valid = 1'b1;
      bus.op_a = fixed ? fa : $urandom;
      bus.op_b = fixed ? fb : $urandom;
      g = 0;
      while (!bus.op_ready && g < 50) begin tick(); g++; end
      chk("op_wait", 128'(g < 50), 128'(1));
      tick();
    end
    bus.op_valid = 1'b0;
    bus.res_ready = 1'b0;
    repeat (hold) tick();
    bus.res_ready = 1'b1;
    g = 0;
    while (!bus.res_valid && g < 50) begin tick(); g++; end
    chk("res_wait", 128'(g < 50), 128'(1));
    res = bus.res_data;
    tick();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] r;
    rst = 1'b1;
    bus.start_valid = 0; bus.start_mode = 0; bus.start_klen = '0; bus.start_bias = '0;
    bus.op_valid = 0; bus.op_a = '0; bus.op_b = '0; bus.res_ready = 0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_start_ready", 128'(bus.start_ready), 128'(1));
    chk("rst_op_ready",    128'(bus.op_ready),    128'(0));
    chk("rst_res_valid",   128'(bus.res_valid),   128'(0));
    chk("rst_mac_in3",     bus.mac_in3,           128'h0);
    chk("rst_res_data",    bus.res_data,          128'h0);
    chk("rst_mac_mode",    128'(bus.mac_mode),    128'(0));

    // operand pulses in idle must be ignored
    repeat (4) begin
      bus.op_valid = 1'b1; bus.op_a = $urandom; bus.op_b = $urandom; tick();
    end
    bus.op_valid = 1'b0;
    chk("idle_acc", bus.mac_in3, 128'h0);

    run_job(1'b1, 2, 128'h0, 1'b1, 32'h04030201, 32'h01010101, 0, 0, r);
    chk("int8_k2", r, 128'h00000008_00000006_00000004_00000002);

    run_job(1'b0, 3, 128'h0, 1'b1, 32'h00000021, 32'h00000011, 3, 0, r);
    chk("int4_gaps", r, 128'h00060003);

    run_job(1'b0, 1, 128'h0000FFFF, 1'b1, 32'h1, 32'h1, 0, 0, r);
    chk("int4_wrap", r, 128'h0);

    run_job(1'b1, 0, 128'h123456789ABCDEF0_0FEDCBA987654321, 1'b0, '0, '0, 0, 5, r);
    chk("k0_bias", r, 128'h123456789ABCDEF0_0FEDCBA987654321);

    // reset in the middle of a 4-beat job
    bus.start_valid = 1'b1; bus.start_mode = 1'b1; bus.start_klen = 8'd4;
    bus.start_bias = 128'h5;
    tick();
    bus.start_valid = 1'b0;
    bus.op_valid = 1'b1; bus.op_a = 32'h01010101; bus.op_b = 32'h02020202;
    tick();
    bus.op_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_acc",       bus.mac_in3,           128'h0);
    chk("midrst_res_valid", 128'(bus.res_valid),   128'(0));
    chk("midrst_idle",      128'(bus.start_ready), 128'(1));
    run_job(1'b1, 1, 128'h0, 1'b1, 32'h05050505, 32'h02020202, 0, 0, r);
    chk("post_rst_job", r, 128'h0000000A_0000000A_0000000A_0000000A);

    // randomized jobs, checked cycle by cycle against the model
    for (int j = 0; j < 40; j++) begin
      run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
              {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0, '0,
              2, int'($urandom_range(0, 3)), r);
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
